// File: rtl/id_stage_if.sv
// Signal bundle between the fetch side, the write-back/EX feedback and the decode stage.
// master drives the fetch, write-back and hazard inputs; slave is the decode stage itself.
interface id_stage_if;
  logic [31:0] pc_if;
  logic [31:0] instruction_if;
  logic        flush;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;

  logic [31:0] pc_id;
  logic [31:0] instruction_id;
  logic        valid_id;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm_id;
  logic        stall_id;

  modport master (
    output pc_if, instruction_if, flush, wb_we, wb_rd, wb_data, ex_mem_read, ex_rd,
    input  pc_id, instruction_id, valid_id, rs1, rs2, rd, rs1_data, rs2_data, imm_id, stall_id
  );

  modport slave (
    input  pc_if, instruction_if, flush, wb_we, wb_rd, wb_data, ex_mem_read, ex_rd,
    output pc_id, instruction_id, valid_id, rs1, rs2, rd, rs1_data, rs2_data, imm_id, stall_id
  );
endinterface

// File: rtl/id_stage.sv
// RV32I decode stage: IF/ID register with flush/stall, 32x32 register file with
// write-first bypass, immediate generation and load-use hazard detection.
module id_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input logic      clk,
  input logic      reset,
  id_stage_if.slave bus
);

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_valid;
  logic [31:0] r_regs [32];

  logic [6:0]  w_opcode;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [4:0]  w_rd;
  logic [31:0] w_imm;
  logic [31:0] w_rs1_data;
  logic [31:0] w_rs2_data;
  logic        w_uses_rs1;
  logic        w_uses_rs2;
  logic        w_stall;
  logic        w_wb_live;

  assign w_opcode  = r_instr[6:0];
  assign w_rs1     = r_instr[19:15];
  assign w_rs2     = r_instr[24:20];
  assign w_rd      = r_instr[11:7];
  assign w_wb_live = bus.wb_we && (bus.wb_rd != 5'd0);

  // IF/ID pipeline register: flush beats stall, stall freezes, otherwise advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc    <= RESET_PC;
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (bus.flush) begin
      r_pc    <= bus.pc_if;
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (!w_stall) begin
      r_pc    <= bus.pc_if;
      r_instr <= bus.instruction_if;
      r_valid <= 1'b1;
    end
  end

  // Register file write port; x0 is never written so it stays at its reset value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wb_live) begin
      r_regs[bus.wb_rd] <= bus.wb_data;
    end
  end

  // Combinational read ports with write-first bypass of the value being written back.
  always_comb begin
    w_rs1_data = '0;
    w_rs2_data = '0;
    if (w_rs1 != 5'd0) begin
      w_rs1_data = (w_wb_live && bus.wb_rd == w_rs1) ? bus.wb_data : r_regs[w_rs1];
    end
    if (w_rs2 != 5'd0) begin
      w_rs2_data = (w_wb_live && bus.wb_rd == w_rs2) ? bus.wb_data : r_regs[w_rs2];
    end
  end

  // Immediate generator, selected by opcode; R-type and unknown opcodes give zero.
  always_comb begin
    w_imm = '0;
    case (w_opcode)
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:
        w_imm = {{20{r_instr[31]}}, r_instr[31:20]};
      OP_STORE:
        w_imm = {{20{r_instr[31]}}, r_instr[31:25], r_instr[11:7]};
      OP_BRANCH:
        w_imm = {{19{r_instr[31]}}, r_instr[31], r_instr[7], r_instr[30:25], r_instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        w_imm = {r_instr[31:12], 12'b0};
      OP_JAL:
        w_imm = {{11{r_instr[31]}}, r_instr[31], r_instr[19:12], r_instr[20], r_instr[30:21], 1'b0};
      default:
        w_imm = '0;
    endcase
  end

  // Load-use hazard: a load in EX whose destination feeds a source read here.
  always_comb begin
    w_uses_rs1 = 1'b1;
    w_uses_rs2 = 1'b0;
    case (w_opcode)
      OP_LUI, OP_AUIPC, OP_JAL:     w_uses_rs1 = 1'b0;
      default:                      w_uses_rs1 = 1'b1;
    endcase
    case (w_opcode)
      OP_REG, OP_STORE, OP_BRANCH:  w_uses_rs2 = 1'b1;
      default:                      w_uses_rs2 = 1'b0;
    endcase
    w_stall = r_valid && bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
              ((w_uses_rs1 && (w_rs1 == bus.ex_rd)) || (w_uses_rs2 && (w_rs2 == bus.ex_rd)));
  end

  assign bus.pc_id          = r_pc;
  assign bus.instruction_id = r_instr;
  assign bus.valid_id       = r_valid;
  assign bus.rs1            = w_rs1;
  assign bus.rs2            = w_rs2;
  assign bus.rd             = w_rd;
  assign bus.rs1_data       = w_rs1_data;
  assign bus.rs2_data       = w_rs2_data;
  assign bus.imm_id         = w_imm;
  assign bus.stall_id       = w_stall;

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode stage directly downstream of instruction fetch.
- Contains the IF/ID pipeline register (stall/flush), a 32x32 integer register file with write-back bypass, the RV32I immediate generator and load-use hazard detection.
- Produces decoded operands for EX, and a stall request that upstream uses to freeze the PC.

Parameters:
- NOP_INSTR, 32'h0000_0013, instruction injected on reset/flush (addi x0,x0,0).
- RESET_PC, 32'h0000_0000, pc_id value after reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high.
- pc_if  input  32  PC of instruction being fetched.
- instruction_if  input  32  fetched instruction.
- flush  input  1  taken branch/jump resolved in EX; kill instruction entering ID.
- wb_we  input  1  write-back enable.
- wb_rd  input  5  write-back destination.
- wb_data  input  32  write-back value.
- ex_mem_read  input  1  instruction currently in EX is a load.
- ex_rd  input  5  destination of instruction in EX.
- pc_id  output  32  registered PC.
- instruction_id  output  32  registered instruction.
- valid_id  output  1  instruction_id is a live instruction.
- rs1  output  5  instruction_id[19:15].
- rs2  output  5  instruction_id[24:20].
- rd  output  5  instruction_id[11:7].
- rs1_data  output  32  operand 1, bypassed.
- rs2_data  output  32  operand 2, bypassed.
- imm_id  output  32  sign-extended immediate.
- stall_id  output  1  load-use stall request; upstream holds PC, EX inserts bubble.

Behaviour:
- Reset (async):
  - pc_id=RESET_PC, instruction_id=NOP_INSTR, valid_id=0.
  - All 32 registers cleared to 0.
  - stall_id=0 as a consequence.
- IF/ID register, per rising edge, in priority order:
  - flush=1 → instruction_id<=NOP_INSTR, valid_id<=0, pc_id<=pc_if. Flush overrides stall.
  - else stall_id=1 → hold pc_id, instruction_id, valid_id.
  - else → pc_id<=pc_if, instruction_id<=instruction_if, valid_id<=1.
- Latency: one cycle from IF inputs to ID outputs. All other outputs are combinational from ID state and inputs.
- Register file:
  - Write at rising edge when wb_we=1 and wb_rd!=0.
  - x0 reads 0 always; writes to x0 are ignored.
  - Reads are combinational.
  - Bypass: if wb_we=1, wb_rd!=0 and wb_rd==rsN, then rsN_data=wb_data in the same cycle (write-first).
- Immediate by opcode[6:0]:
  - I-type (0010011, 0000011, 1100111, 1110011): sext(inst[31:20]).
  - S-type (0100011): sext({inst[31:25],inst[11:7]}).
  - B-type (1100011): sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
  - U-type (0110111, 0010111): {inst[31:12],12'b0}.
  - J-type (1101111): sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
  - R-type and any other opcode: 0.
- Hazard detection:
  - uses_rs1: every opcode except U and J.
  - uses_rs2: R (0110011), S, B.
  - stall_id = valid_id & ex_mem_read & (ex_rd!=0) & ((uses_rs1 & rs1==ex_rd) | (uses_rs2 & rs2==ex_rd)).
  - A stall lasts exactly one cycle under a well-behaved EX, which drops ex_mem_read once the bubble enters EX.
- Boundary conditions:
  - valid_id=0 never stalls.
  - flush and stall in the same cycle → flush wins, and stall drops next cycle.
  - Reset mid-stall clears everything immediately.
  - wb write and read of the same register in the same cycle → new value via bypass.

Test Plan:
- Reset asserted mid-run → pc_id=0, instruction_id=32'h13, valid_id=0, all registers read 0 after release; first edge after release captures pc_if=0, valid_id=1.
- Write x5=32'hDEAD_BEEF (wb_we=1,wb_rd=5) while ID holds add x1,x5,x5 → rs1_data=rs2_data=32'hDEAD_BEEF in that cycle (bypass) and on later cycles; a write of 32'h1234 to x0 → x0 still reads 0.
- Immediates: 32'hFFF00093 → imm_id=32'hFFFF_FFFF; sw 32'hFE112E23 → 32'hFFFF_FFFC; beq 32'hFE000EE3 → 32'hFFFF_FFFC; lui 32'h123450B7 → 32'h1234_5000; jal 32'h0080006F → 32'h0000_0008.
- Load-use: ex_mem_read=1, ex_rd=3, ID holds add x4,x3,x2 → stall_id=1; pc_id/instruction_id hold one edge; ex_mem_read drops → stall_id=0 and the next edge captures the new instruction. Same case with lui x3 in ID → no stall.
- flush=1 together with an active stall → next edge gives instruction_id=32'h13, valid_id=0, pc_id=pc_if, stall_id=0.
- Sequential PCs 0,4,8,C with no hazards → pc_id follows one cycle behind and valid_id stays 1.
